digit_scan_mux: RTL and testbench
=================================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, clk cycles per digit slot (legal 2..2^20).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, fixed at 4; other values are illegal.
REQ-003 clk  input  1  single system clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 value  input  16  four BCD/hex nibbles, digit k = value[4k+3:4k], digit 0 is rightmost.
REQ-006 dp_in  input  4  decimal-point request per digit, 1 = lit.
REQ-007 load  input  1  one-cycle strobe that captures value and dp_in.
REQ-008 blank_lz  input  1  1 = blank leading zero digits.
REQ-009 load_ack  output  1  one-cycle pulse when a loaded value becomes displayed.
REQ-010 bin  output  4  nibble of the active digit, feeding the downstream segment decoder.
REQ-011 an  output  4  digit enables, active-low, at most one low.
REQ-012 dp  output  1  decimal point of the active digit, active-low.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick = (count == CLK_DIV-1).
REQ-014 Digit index SHALL advance on tick: 0->1->2->3->0.
- frame boundary = tick with index == 3.
REQ-015 Display register disp[15:0] and dpr[3:0] SHALL change only at a frame boundary (no mid-frame tearing).
REQ-016 On load, value/dp_in SHALL be captured into a pending register and pend_valid set.
- load while pend_valid is already set: overwrites pending; latest wins, no ack for the overwritten value.
REQ-017 At a frame boundary with pend_valid = 1:
- disp/dpr <= pending; pend_valid cleared; load_ack = 1 on the following cycle for one cycle.
REQ-018 load coincident with a frame boundary:
- the value on value/dp_in that cycle SHALL go directly to disp/dpr and be acked.
- pend_valid ends cleared.
REQ-019 Outputs SHALL be registered, one cycle after the index update:
- bin = disp nibble[index]; dp = ~dpr[index]; an = all ones except bit[index] = 0.
REQ-020 Leading-zero blanking: with blank_lz = 1, digit k > 0 SHALL be blanked when nibbles k..3 of disp are all zero.
- digit 0 is never blanked.
- blanking is evaluated combinationally from disp and blank_lz each slot.
REQ-021 Blanked digit: an = 4'b1111, dp = 1, bin = 0.
REQ-022 Between frame boundaries, value, dp_in and blank_lz changes without load SHALL NOT change bin/dp; blank_lz SHALL affect an from the next registered output.

Reset
REQ-023 While rst_n = 0 at a clk edge, the block SHALL set:
- count = 0, index = 0, disp = 0, dpr = 0, pend_valid = 0
- an = 4'b1111, bin = 0, dp = 1, load_ack = 0
REQ-024 load asserted during reset SHALL be ignored.
REQ-025 Reset mid-frame SHALL discard pending data.
REQ-026 After reset release, digit 0 SHALL be enabled on the first clock edge; the next advance occurs CLK_DIV cycles later.

Structure
REQ-027 A shared package SHALL hold DIGITS = 4, the digit-index typedef (2 bits) and the an one-hot-low encoding function.
REQ-028 The prescaler SHALL be a sub-module scan_tick_gen, parameterised by CLK_DIV, outputting tick.
REQ-029 The segment decoder SHALL NOT be part of this block; bin connects to it externally.

Verification (CLK_DIV = 4)
REQ-030 Reset scenario: after reset, an = 1110, bin = 0, dp = 1; an rotates 1101, 1011, 0111, 1110 every 4 cycles.
REQ-031 Load scenario: load value = 16'h1234, dp_in = 4'b0100 mid-frame.
- display stays at 0 until the frame boundary; load_ack pulses once.
- next frame bin sequence = 4, 3, 2, 1; dp = 0 only on digit 2.
REQ-032 Overwrite scenario: load 16'hAAAA, then 16'h5555 before the boundary.
- single load_ack; displayed value is 5555.
REQ-033 Coincident load scenario: load 16'hBEEF exactly at the boundary.
- next frame shows F, E, E, B; one load_ack.
REQ-034 Blanking scenario: blank_lz = 1 and load 16'h0007.
- an is low only for digit 0, with bin = 7; other slots an = 1111.
- load 16'h0000: digit 0 shows 0.
REQ-035 Reset mid-frame scenario: rst_n low for one cycle with pend_valid set.
- all outputs return to REQ-023 values; no load_ack; disp = 0.

Source files
------------

// File: rtl/digit_scan_mux_pkg.sv
// Shared constants, digit-index type and anode/blanking helpers for the scan mux.
package digit_scan_mux_pkg;

  localparam int DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [DIGITS-1:0] an_onehot_low(input digit_idx_t idx);
    return ~(DIGITS'(1) << idx);
  endfunction

  // Digit 0 always shows; higher digits blank when they and everything above are zero.
  function automatic logic lz_blank(input logic [15:0] disp, input digit_idx_t idx);
    return (idx != 2'd0) && ((disp >> {idx, 2'b00}) == 16'h0000);
  endfunction

endpackage

// File: rtl/digit_scan_mux_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and flags the last count as the slot tick.
module scan_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Four-digit time-multiplexed display driver; new values take effect only at frame
// boundaries, and all display outputs are registered one cycle behind the digit index.
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic [3:0]  bin,
  output logic [3:0]  an,
  output logic        dp
);

  if (NUM_DIGITS != DIGITS) begin : g_bad_num_digits
    $error("digit_scan_mux supports exactly four digits");
  end

  logic        tick;
  logic        frame;
  logic        blank;

  digit_idx_t  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  dpr_q, dpr_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  pdp_q, pdp_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ack_q, ack_d;
  logic [3:0]  bin_q, bin_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame = tick && (idx_q == 2'd3);
  assign blank = blank_lz && lz_blank(disp_q, idx_q);

  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    disp_d     = disp_q;
    dpr_d      = dpr_q;
    pend_d     = pend_q;
    pdp_d      = pdp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;

    // A load landing on the boundary bypasses the pending register entirely.
    if (frame) begin
      if (load) begin
        disp_d     = value;
        dpr_d      = dp_in;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end else if (pend_vld_q) begin
        disp_d     = pend_q;
        dpr_d      = pdp_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
    end else if (load) begin
      pend_d     = value;
      pdp_d      = dp_in;
      pend_vld_d = 1'b1;
    end

    if (blank) begin
      an_d  = 4'b1111;
      bin_d = 4'h0;
      dp_d  = 1'b1;
    end else begin
      an_d  = an_onehot_low(idx_q);
      bin_d = disp_q[{idx_q, 2'b00} +: 4];
      dp_d  = ~dpr_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      dpr_q      <= 4'h0;
      pend_q     <= 16'h0000;
      pdp_q      <= 4'h0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      bin_q      <= 4'h0;
      an_q       <= 4'b1111;
      dp_q       <= 1'b1;
    end else begin
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      dpr_q      <= dpr_d;
      pend_q     <= pend_d;
      pdp_q      <= pdp_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      bin_q      <= bin_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign load_ack = ack_q;
  assign bin      = bin_q;
  assign an       = an_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench for digit_scan_mux at CLK_DIV = 4 (16-cycle frames).
module tb_digit_scan_mux;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ack;
  logic [3:0]  bin;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] bin;
    logic       dp;
  } slot_t;

  slot_t sbq[$];
  int    ackq[$];

  digit_scan_mux #(.CLK_DIV(DIV), .NUM_DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .load_ack (load_ack),
    .bin      (bin),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset was last released
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_slot(input int c, input logic [3:0] a, input logic [3:0] b, input logic d);
    slot_t s;
    s.cyc = c;
    s.an  = a;
    s.bin = b;
    s.dp  = d;
    sbq.push_back(s);
  endtask

  // Expected display of frame f, derived directly from the displayed value.
  task automatic push_frame(input int f, input logic [15:0] v, input logic [3:0] d, input logic blk);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] upper;
      logic        blanked;
      logic [3:0]  a;
      upper   = v >> (4 * k);
      blanked = blk && (k > 0) && (upper == 16'h0000);
      a       = 4'b1111;
      if (!blanked) a[k] = 1'b0;
      push_slot(FRAME * f + 2 + DIV * k, a, blanked ? 4'h0 : upper[3:0], blanked ? 1'b1 : ~d[k]);
    end
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) chk("goto_timeout", cyc, n);
  endtask

  // Load is sampled at rising edge e; afterwards inputs wander without a load.
  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] d);
    goto(e - 1);
    value = v;
    dp_in = d;
    load  = 1'b1;
    goto(e);
    load  = 1'b0;
    value = 16'($urandom);
    dp_in = 4'($urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, an, 4'b1111);
    chk({tag, "_bin"}, bin, 4'h0);
    chk({tag, "_dp"}, dp, 1'b1);
    chk({tag, "_ack"}, load_ack, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc < cyc && rst_n) begin
      chk("sb_missed", cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end else if (sbq.size() > 0 && sbq[0].cyc == cyc && rst_n) begin
      chk($sformatf("an@%0d", cyc), an, sbq[0].an);
      chk($sformatf("bin@%0d", cyc), bin, sbq[0].bin);
      chk($sformatf("dp@%0d", cyc), dp, sbq[0].dp);
      void'(sbq.pop_front());
    end
    if (ackq.size() > 0 && ackq[0] == cyc && rst_n) begin
      chk($sformatf("load_ack@%0d", cyc), load_ack, 1'b1);
      void'(ackq.pop_front());
    end else if (load_ack) begin
      chk($sformatf("load_ack_spurious@%0d", cyc), load_ack, 1'b0);
    end
  end

  initial begin
    // Reset with a load held active: it must be ignored.
    rst_n = 1'b0;
    load  = 1'b1;
    value = 16'hFFFF;
    dp_in = 4'hF;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    load  = 1'b0;
    rst_n = 1'b1;

    // Frame 0 shows zero while 1234 waits for the boundary.
    push_frame(0, 16'h0000, 4'h0, 1'b0);
    push_frame(1, 16'h1234, 4'b0100, 1'b0);
    ackq.push_back(FRAME);
    do_load(6, 16'h1234, 4'b0100);

    // Overwrite before the boundary: only the latest value, one ack.
    push_frame(2, 16'h1234, 4'b0100, 1'b0);
    push_frame(3, 16'h5555, 4'b0000, 1'b0);
    ackq.push_back(3 * FRAME);
    do_load(36, 16'hAAAA, 4'b0001);
    do_load(40, 16'h5555, 4'b0000);

    // Load exactly on the frame boundary.
    push_frame(4, 16'hBEEF, 4'b0000, 1'b0);
    ackq.push_back(4 * FRAME);
    do_load(4 * FRAME, 16'hBEEF, 4'b0000);

    // Leading-zero blanking, including suppressed decimal points.
    blank_lz = 1'b1;
    push_frame(5, 16'h0007, 4'b1111, 1'b1);
    ackq.push_back(5 * FRAME);
    do_load(70, 16'h0007, 4'b1111);

    push_frame(6, 16'h0000, 4'b0000, 1'b0);
    ackq.push_back(6 * FRAME);
    do_load(84, 16'h0000, 4'b0000);

    // Blanking turned off during digit 0 takes effect from the next slot.
    goto(6 * FRAME + 3);
    blank_lz = 1'b0;

    push_slot(7 * FRAME + 2, 4'b1110, 4'h0, 1'b1);
    push_slot(7 * FRAME + 2 + DIV, 4'b1101, 4'h0, 1'b1);
    do_load(118, 16'h9999, 4'b1111);

    // One-cycle reset mid-frame with data pending.
    goto(119);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    rst_n = 1'b1;

    push_frame(0, 16'h0000, 4'h0, 1'b0);
    push_slot(FRAME + 2, 4'b1110, 4'h0, 1'b1);
    goto(FRAME + 8);

    chk("sb_empty", sbq.size(), 0);
    chk("ackq_empty", ackq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
